// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and load/store.
// Round-robin (or fixed) arbitration, 2-cycle read sequencing, RMW for partial stores.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [31:0]           if_req_addr,
    output logic                  if_rsp_valid,
    output logic [31:0]           if_rsp_rdata,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [31:0]           ls_req_addr,
    input  logic                  ls_req_we,
    input  logic [3:0]            ls_req_wstrb,
    input  logic [31:0]           ls_req_wdata,
    output logic                  ls_rsp_valid,
    output logic [31:0]           ls_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [31:0]           mem_data,
    output logic                  mem_sel,
    output logic                  mem_we,
    output logic                  mem_en,
    output logic                  busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_WR   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  is_ls_q, is_ls_d;
    logic                  is_wr_q, is_wr_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  last_ls_q, last_ls_d;
    logic                  if_rsp_valid_q, if_rsp_valid_d;
    logic [DATA_W-1:0]     if_rsp_rdata_q, if_rsp_rdata_d;
    logic                  ls_rsp_valid_q, ls_rsp_valid_d;
    logic [DATA_W-1:0]     ls_rsp_rdata_q, ls_rsp_rdata_d;
    logic                  mem_sel_q, mem_sel_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_en_q, mem_en_d;

    logic                  ls_pri_c;
    logic                  if_win_c;
    logic                  ls_win_c;
    logic [DATA_W-1:0]     merged_c;
    logic                  unused_addr_bits;

    // Only the word-index bits of the byte addresses are used; the rest alias.
    assign unused_addr_bits = ^{if_req_addr, ls_req_addr};

    // Load/store wins a tie when fixed priority is set or fetch was granted last.
    assign ls_pri_c = (FIXED_PRIO != 0) || !last_ls_q;
    assign if_win_c = rst_n && (state_q == S_IDLE) && if_req_valid && !(ls_req_valid && ls_pri_c);
    assign ls_win_c = rst_n && (state_q == S_IDLE) && ls_req_valid && !(if_req_valid && !ls_pri_c);

    assign if_req_ready = if_win_c;
    assign ls_req_ready = ls_win_c;

    // Strobed bytes from the store data, remaining bytes from the word read back.
    always_comb begin
        merged_c = mem_data;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (wstrb_q[i]) begin
                merged_c[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        is_ls_d        = is_ls_q;
        is_wr_d        = is_wr_q;
        wstrb_d        = wstrb_q;
        wdata_d        = wdata_q;
        last_ls_d      = last_ls_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_rdata_d = if_rsp_rdata_q;
        ls_rsp_valid_d = 1'b0;
        ls_rsp_rdata_d = ls_rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_win_c) begin
                    addr_d    = if_req_addr[ADDR_WIDTH+1:2];
                    is_ls_d   = 1'b0;
                    is_wr_d   = 1'b0;
                    last_ls_d = 1'b0;
                    state_d   = S_RD;
                end else if (ls_win_c) begin
                    addr_d    = ls_req_addr[ADDR_WIDTH+1:2];
                    is_ls_d   = 1'b1;
                    is_wr_d   = ls_req_we;
                    wstrb_d   = ls_req_wstrb;
                    wdata_d   = ls_req_wdata;
                    last_ls_d = 1'b1;
                    if (!ls_req_we) begin
                        state_d = S_RD;
                    end else if (ls_req_wstrb == 4'b1111) begin
                        state_d = S_WR;
                    end else if (ls_req_wstrb == 4'b0000) begin
                        ls_rsp_valid_d = 1'b1;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (is_wr_q) begin
                    wdata_d = merged_c;
                    state_d = S_WR;
                end else begin
                    if (is_ls_q) begin
                        ls_rsp_valid_d = 1'b1;
                        ls_rsp_rdata_d = mem_data;
                    end else begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_rdata_d = mem_data;
                    end
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                ls_rsp_valid_d = 1'b1;
                ls_rsp_rdata_d = wdata_q;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // SRAM strobes follow the state being entered so they line up with it.
        mem_sel_d = (state_d != S_IDLE);
        mem_we_d  = (state_d == S_WR);
        mem_en_d  = (state_d == S_CAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            is_ls_q        <= 1'b0;
            is_wr_q        <= 1'b0;
            wstrb_q        <= '0;
            wdata_q        <= '0;
            last_ls_q      <= 1'b1;
            if_rsp_valid_q <= 1'b0;
            if_rsp_rdata_q <= '0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_rdata_q <= '0;
            mem_sel_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            is_ls_q        <= is_ls_d;
            is_wr_q        <= is_wr_d;
            wstrb_q        <= wstrb_d;
            wdata_q        <= wdata_d;
            last_ls_q      <= last_ls_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_rdata_q <= if_rsp_rdata_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_rdata_q <= ls_rsp_rdata_d;
            mem_sel_q      <= mem_sel_d;
            mem_we_q       <= mem_we_d;
            mem_en_q       <= mem_en_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_sel      = mem_sel_q;
    assign mem_we       = mem_we_q;
    assign mem_en       = mem_en_q;
    assign mem_data     = mem_we_q ? wdata_q : 32'hzzzz_zzzz;
    assign busy         = (state_q != S_IDLE);
    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_rdata = if_rsp_rdata_q;
    assign ls_rsp_valid = ls_rsp_valid_q;
    assign ls_rsp_rdata = ls_rsp_rdata_q;

endmodule
